// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two masters and the ALU arbiter.
// valid/ready: a transfer happens on a rising edge where both are high.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 6
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_carry, rsp_zero,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_carry, rsp_zero,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that serialises two requesters onto one combinational
// ALU: registered operands in, one settle cycle, registered result out.
module alu_share_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arbiter_if.slave bus,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             busy,
  output logic [1:0]       dbg_state,
  output logic             dbg_last_grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             gnt_any;
  logic             gnt_idx;

  // Grant is only ever raised toward a requester that is valid, so a grant
  // is also the completed request handshake.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt_any = 1'b1;
        gnt_idx = ~last_grant_q;
      end else if (bus.req0_valid) begin
        gnt_any = 1'b1;
        gnt_idx = 1'b0;
      end else if (bus.req1_valid) begin
        gnt_any = 1'b1;
        gnt_idx = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          owner_d = gnt_idx;
          ctrl_d  = gnt_idx ? bus.req1_op : bus.req0_op;
          a_d     = gnt_idx ? bus.req1_a  : bus.req0_a;
          b_d     = gnt_idx ? bus.req1_b  : bus.req0_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = alu_out;
        carry_d = alu_carry;
        zero_d  = alu_zero;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
    end
  end

  assign bus.req0_ready = gnt_any && !gnt_idx;
  assign bus.req1_ready = gnt_any && gnt_idx;
  assign bus.rsp_valid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_zero   = zero_q;

  assign alu_ctrl       = ctrl_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state      = state_q;
  assign dbg_last_grant = last_grant_q;

endmodule
